// File: rtl/alu_instr_seq.sv
// Program sequencer feeding the 4-bit alu: fetches {opcode,in1,in2} words and streams tagged results.
// Optional build macro ALU_SEQ_LOOP_EN makes the program repeat until abort instead of a single pass.
module alu_instr_seq #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [11:0]   load_data,
   input  logic [AW-1:0] last_addr,
   input  logic          start,
   input  logic          abort,
   output logic [3:0]    opcode,
   output logic [3:0]    in1,
   output logic [3:0]    in2,
   input  logic [3:0]    alu_result,
   output logic          res_valid,
   output logic [3:0]    res_data,
   output logic [AW-1:0] res_idx,
   output logic          busy,
   output logic          done
);

   localparam int unsigned IW = 12;
   localparam int unsigned DW = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_DONE
   } state_t;

   logic [IW-1:0] mem [DEPTH];
   logic [IW-1:0] fetch_word_c;

   state_t        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [AW-1:0] last_q, last_d;
   logic [DW-1:0] opcode_q, opcode_d;
   logic [DW-1:0] in1_q, in1_d;
   logic [DW-1:0] in2_q, in2_d;
   logic [DW-1:0] res_data_q, res_data_d;
   logic [AW-1:0] res_idx_q, res_idx_d;
   logic          res_valid_q, res_valid_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   // Program store: not reset, writable only while idle.
   always_ff @(posedge clk) begin
      if (state_q == S_IDLE && load_en) begin
         mem[load_addr] <= load_data;
      end
   end

   assign fetch_word_c = mem[pc_q];

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      last_d      = last_q;
      opcode_d    = opcode_q;
      in1_d       = in1_q;
      in2_d       = in2_q;
      res_data_d  = res_data_q;
      res_idx_d   = res_idx_q;
      res_valid_d = 1'b0;
      done_d      = 1'b0;

      // Abort overrides every other action of an active run.
      if (abort && state_q != S_IDLE) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  pc_d    = '0;
                  last_d  = last_addr;
                  state_d = S_FETCH;
               end
            end
            S_FETCH: begin
               opcode_d = fetch_word_c[11:8];
               in1_d    = fetch_word_c[7:4];
               in2_d    = fetch_word_c[3:0];
               state_d  = S_EXEC;
            end
            S_EXEC: begin
               res_data_d  = alu_result;
               res_idx_d   = pc_q;
               res_valid_d = 1'b1;
               if (pc_q == last_q) begin
`ifdef ALU_SEQ_LOOP_EN
                  pc_d    = '0;
                  done_d  = 1'b1;
                  state_d = S_FETCH;
`else
                  state_d = S_DONE;
`endif
               end else begin
                  pc_d    = pc_q + AW'(1);
                  state_d = S_FETCH;
               end
            end
            S_DONE: begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      busy_d = (state_d == S_FETCH) || (state_d == S_EXEC);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         pc_q        <= '0;
         last_q      <= '0;
         opcode_q    <= '0;
         in1_q       <= '0;
         in2_q       <= '0;
         res_data_q  <= '0;
         res_idx_q   <= '0;
         res_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         last_q      <= last_d;
         opcode_q    <= opcode_d;
         in1_q       <= in1_d;
         in2_q       <= in2_d;
         res_data_q  <= res_data_d;
         res_idx_q   <= res_idx_d;
         res_valid_q <= res_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign opcode    = opcode_q;
   assign in1       = in1_q;
   assign in2       = in2_q;
   assign res_data  = res_data_q;
   assign res_idx   = res_idx_q;
   assign res_valid = res_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_alu_instr_seq.sv
// Directed bench for alu_instr_seq with a small behavioural alu closing the loop.
module tb_alu_instr_seq;

   logic        clk;
   logic        rst_n;
   logic        load_en;
   logic [3:0]  load_addr;
   logic [11:0] load_data;
   logic [3:0]  last_addr;
   logic        start;
   logic        abort;
   logic [3:0]  opcode, in1, in2;
   logic [3:0]  alu_result;
   logic        res_valid;
   logic [3:0]  res_data;
   logic [3:0]  res_idx;
   logic        busy;
   logic        done;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int start_cyc;
   int done_cyc;
   logic [11:0] pm [16];
   logic [3:0]  idx_q [$];
   logic [3:0]  data_q [$];
   int          cyc_q [$];

   alu_instr_seq #(.DEPTH(16), .AW(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_en    (load_en),
      .load_addr  (load_addr),
      .load_data  (load_data),
      .last_addr  (last_addr),
      .start      (start),
      .abort      (abort),
      .opcode     (opcode),
      .in1        (in1),
      .in2        (in2),
      .alu_result (alu_result),
      .res_valid  (res_valid),
      .res_data   (res_data),
      .res_idx    (res_idx),
      .busy       (busy),
      .done       (done)
   );

   function automatic logic [3:0] alu_f(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return ~a;
         default: return a;
      endcase
   endfunction

   function automatic logic [3:0] exp_data(input int i);
      logic [11:0] w;
      w = pm[i];
      return alu_f(w[11:8], w[7:4], w[3:0]);
   endfunction

   assign alu_result = alu_f(opcode, in1, in2);

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic load_word(input logic [3:0] a, input logic [11:0] d);
      load_en = 1'b1; load_addr = a; load_data = d;
      @(negedge clk);
      load_en = 1'b0;
      pm[a] = d;
   endtask

   // Pulses start (optionally with a same-edge load), then records results until done or timeout.
   task automatic run_prog(input logic [3:0] last, input logic ld, input logic [3:0] la,
                           input logic [11:0] ldat, input int poke, input int max_cyc);
      idx_q.delete(); data_q.delete(); cyc_q.delete();
      done_cyc  = -1;
      start     = 1'b1; last_addr = last;
      load_en   = ld; load_addr = la; load_data = ldat;
      @(negedge clk);
      if (ld) pm[la] = ldat;
      start = 1'b0; load_en = 1'b0;
      start_cyc = cyc;
      check_eq("busy_after_start", 32'(busy), 32'd1);
      for (int k = 0; k < max_cyc; k++) begin
         if (k < poke) begin
            load_en = 1'b1; load_addr = 4'd1; load_data = 12'hFFF; start = 1'b1;
         end else begin
            load_en = 1'b0; start = 1'b0;
         end
         @(negedge clk);
         if (res_valid) begin
            idx_q.push_back(res_idx);
            data_q.push_back(res_data);
            cyc_q.push_back(cyc);
         end
         if (done) begin
            done_cyc = cyc;
            break;
         end
      end
      load_en = 1'b0; start = 1'b0;
      if (done_cyc < 0) check_eq("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic check_run(input string tag, input int n);
      check_eq({tag, ".count"}, 32'(idx_q.size()), 32'(n));
      for (int i = 0; i < n && i < idx_q.size(); i++) begin
         check_eq({tag, ".idx"}, 32'(idx_q[i]), 32'(i));
         check_eq({tag, ".data"}, 32'(data_q[i]), 32'(exp_data(i)));
         check_eq({tag, ".cyc"}, 32'(cyc_q[i]), 32'(start_cyc + 2 + 2 * i));
      end
      check_eq({tag, ".done_cyc"}, 32'(done_cyc), 32'(start_cyc + 2 * n + 1));
   endtask

   task automatic wait_valid(input string tag, input int bound);
      for (int k = 0; k < bound; k++) begin
         @(negedge clk);
         if (res_valid) return;
      end
      check_eq({tag, ".valid_timeout"}, 32'd0, 32'd1);
   endtask

   function automatic logic [31:0] out_bundle();
      return 32'({opcode, in1, in2, res_data, res_idx, res_valid, busy, done});
   endfunction

   initial begin
      int extra;
      rst_n = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
      last_addr = '0; start = 1'b0; abort = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("reset_outputs", out_bundle(), 32'd0);

      load_word(4'd0, 12'h123);
      load_word(4'd1, 12'h234);
      load_word(4'd2, 12'h345);
      for (int i = 3; i < 16; i++) load_word(4'(i), {4'(i % 8), 4'(i), 4'(15 - i)});

`ifdef ALU_SEQ_LOOP_EN
      run_prog(4'd1, 1'b0, 4'd0, 12'h000, 0, 0);
      extra = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (res_valid) begin
            check_eq("loop.idx", 32'(res_idx), 32'(extra % 2));
            check_eq("loop.done", 32'(done), 32'(res_idx == 4'd1));
            extra++;
         end
         check_eq("loop.busy", 32'(busy), 32'd1);
      end
      check_eq("loop.count", 32'(extra), 32'd6);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_eq("loop.abort_busy", 32'(busy), 32'd0);
      check_eq("loop.abort_valid", 32'(res_valid), 32'd0);
`else
      // Basic three-word program.
      run_prog(4'd2, 1'b0, 4'd0, 12'h000, 0, 20);
      check_run("t1", 3);
      check_eq("t1.hold_instr", 32'({opcode, in1, in2}), 32'h345);
      check_eq("t1.busy_idle", 32'(busy), 32'd0);

      // Async reset during EXEC of word 1, then rerun from the retained program.
      start = 1'b1; last_addr = 4'd2;
      @(negedge clk);
      start = 1'b0;
      wait_valid("t2", 10);
      @(posedge clk);
      #2;
      check_eq("t2.exec_word1", 32'({opcode, in1, in2}), 32'h234);
      rst_n = 1'b0;
      #1;
      check_eq("t2.async_clear", out_bundle(), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_prog(4'd2, 1'b0, 4'd0, 12'h000, 0, 20);
      check_run("t2.rerun", 3);

      // Loads and starts while busy must be ignored.
      run_prog(4'd2, 1'b0, 4'd0, 12'h000, 3, 20);
      check_run("t3", 3);

      // Single instruction, with a same-edge load of word 0.
      run_prog(4'd0, 1'b1, 4'd0, 12'h0A7, 0, 20);
      check_run("t4.single", 1);

      // Full depth, then confirm no wrap.
      run_prog(4'd15, 1'b0, 4'd0, 12'h000, 0, 50);
      check_run("t4.full", 16);
      extra = 0;
      repeat (4) begin
         @(negedge clk);
         if (res_valid || done) extra++;
      end
      check_eq("t4.no_wrap", 32'(extra), 32'd0);
      check_eq("t4.busy_idle", 32'(busy), 32'd0);

      // Abort during EXEC of idx 1.
      start = 1'b1; last_addr = 4'd2;
      @(negedge clk);
      start = 1'b0;
      wait_valid("t5", 10);
      check_eq("t5.idx0", 32'(res_idx), 32'd0);
      @(negedge clk);
      check_eq("t5.busy_exec", 32'(busy), 32'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_eq("t5.no_valid", 32'(res_valid), 32'd0);
      check_eq("t5.no_done", 32'(done), 32'd0);
      check_eq("t5.busy_low", 32'(busy), 32'd0);
      extra = 0;
      repeat (4) begin
         @(negedge clk);
         if (res_valid || done) extra++;
      end
      check_eq("t5.quiet", 32'(extra), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
